// File: rtl/rvx_timer_scheduler.sv
// rvx_timer_scheduler: multiplexes NUM_CHANNELS 64-bit deadlines
// onto one machine timer, programming mtimecmp with the earliest.
//
// Ports:
//   clock, reset         sync active-high reset
//   cmd_valid/op/channel/deadline, cmd_ready
//                        host arm(0)/cancel(1) command port
//   expired_pending      sticky per-channel expiry flags
//   expired_clear        write-1-to-clear for expired_pending
//   timer_irq            registered OR of expired_pending
//   mt_address/write_data/write_strobe/write_request
//                        write master toward the timer
//   mt_write_response    timer write acknowledge
//   mt_irq               timer interrupt (mtime >= mtimecmp)
module rvx_timer_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic                    cmd_op,
  input  logic [CH_W-1:0]         cmd_channel,
  input  logic [63:0]             cmd_deadline,
  output logic                    cmd_ready,
  output logic [NUM_CHANNELS-1:0] expired_pending,
  input  logic [NUM_CHANNELS-1:0] expired_clear,
  output logic                    timer_irq,
  output logic [4:0]              mt_address,
  output logic [31:0]             mt_write_data,
  output logic [3:0]              mt_write_strobe,
  output logic                    mt_write_request,
  input  logic                    mt_write_response,
  input  logic                    mt_irq
);

  localparam logic [4:0] ADDR_CR   = 5'h00;
  localparam logic [4:0] ADDR_CMPL = 5'h0C;
  localparam logic [4:0] ADDR_CMPH = 5'h10;

  typedef enum logic [2:0] {
    INIT,
    SCAN,
    WR_HMAX,
    WR_LO,
    WR_HI,
    SETTLE,
    ARMED
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_CHANNELS-1:0] valid;
  logic [63:0]             deadline [NUM_CHANNELS];
  logic [63:0]             target_deadline;
  logic                    target_valid;
  logic [63:0]             scan_min;
  logic                    scan_hit;
  logic [NUM_CHANNELS-1:0] hit_mask;
  logic                    cr_sent;
  logic                    wr_done;
  logic                    accept;
  logic                    expire;

  // A response in the request cycle can only be stale.
  assign wr_done = mt_write_response & ~mt_write_request;

  assign cmd_ready =
    (state == ARMED) & ~(mt_irq & target_valid);
  assign accept = cmd_valid & cmd_ready;
  assign expire =
    (state == ARMED) & mt_irq & target_valid;

  assign mt_write_strobe = 4'hF;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    scan_min = '1;
    scan_hit = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (valid[i] &&
          (!scan_hit || deadline[i] < scan_min)) begin
        scan_min = deadline[i];
        scan_hit = 1'b1;
      end
    end
  end

  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      hit_mask[i] = expire & valid[i] &
        (deadline[i] <= target_deadline);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      INIT:    if (cr_sent && wr_done)
                 state_next = SCAN;
      SCAN:    state_next = WR_HMAX;
      WR_HMAX: if (wr_done) state_next = WR_LO;
      WR_LO:   if (wr_done) state_next = WR_HI;
      WR_HI:   if (wr_done) state_next = SETTLE;
      SETTLE:  state_next = ARMED;
      ARMED:   if (expire || accept)
                 state_next = SCAN;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= INIT;
      valid           <= '0;
      target_valid    <= 1'b0;
      target_deadline <= '1;
      expired_pending <= '0;
      timer_irq       <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++)
        deadline[i] <= '0;
    end else begin
      state <= state_next;
      if (state == SCAN) begin
        target_valid    <= scan_hit;
        target_deadline <= scan_min;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (hit_mask[i]) begin
          valid[i] <= 1'b0;
        end else if (accept &&
                     cmd_channel == CH_W'(i)) begin
          valid[i] <= ~cmd_op;
          if (!cmd_op)
            deadline[i] <= cmd_deadline;
        end
      end
      // Expiry set beats a same-cycle clear.
      expired_pending <=
        (expired_pending & ~expired_clear) | hit_mask;
      timer_irq <= |expired_pending;
    end
  end

  // CMPH is parked at all-ones first so the
  // half-written compare never fires early.
  always_ff @(posedge clock) begin
    if (reset) begin
      mt_write_request <= 1'b0;
      mt_address       <= '0;
      mt_write_data    <= '0;
      cr_sent          <= 1'b0;
    end else begin
      mt_write_request <= 1'b0;
      unique case (1'b1)
        (state == INIT) && !cr_sent: begin
          mt_write_request <= 1'b1;
          mt_address       <= ADDR_CR;
          mt_write_data    <= 32'h1;
          cr_sent          <= 1'b1;
        end
        state == SCAN: begin
          mt_write_request <= 1'b1;
          mt_address       <= ADDR_CMPH;
          mt_write_data    <= '1;
        end
        (state == WR_HMAX) && wr_done: begin
          mt_write_request <= 1'b1;
          mt_address       <= ADDR_CMPL;
          mt_write_data    <= target_deadline[31:0];
        end
        (state == WR_LO) && wr_done: begin
          mt_write_request <= 1'b1;
          mt_address       <= ADDR_CMPH;
          mt_write_data    <= target_deadline[63:32];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rvx_timer_scheduler.sv
// tb_rvx_timer_scheduler: directed bench for rvx_timer_scheduler
// with a small behavioural mtimer model.
module tb_rvx_timer_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_op = 1'b0;
  logic [1:0]  cmd_channel = '0;
  logic [63:0] cmd_deadline = '0;
  logic        cmd_ready;
  logic [3:0]  expired_pending;
  logic [3:0]  expired_clear = '0;
  logic        timer_irq;
  logic [4:0]  mt_address;
  logic [31:0] mt_write_data;
  logic [3:0]  mt_write_strobe;
  logic        mt_write_request;
  logic        mt_write_response;
  logic        mt_irq;

  localparam logic [63:0] ONES = '1;

  int tests = 0;
  int fails = 0;

  rvx_timer_scheduler #(.NUM_CHANNELS(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_op            (cmd_op),
    .cmd_channel       (cmd_channel),
    .cmd_deadline      (cmd_deadline),
    .cmd_ready         (cmd_ready),
    .expired_pending   (expired_pending),
    .expired_clear     (expired_clear),
    .timer_irq         (timer_irq),
    .mt_address        (mt_address),
    .mt_write_data     (mt_write_data),
    .mt_write_strobe   (mt_write_strobe),
    .mt_write_request  (mt_write_request),
    .mt_write_response (mt_write_response),
    .mt_irq            (mt_irq)
  );

  always #5 clock = ~clock;

  // mtimer model: 2-cycle writes, registered irq
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        mt_en;
  logic        load = 1'b0;
  logic [63:0] load_val = '0;
  logic [36:0] wlog [$];

  always @(posedge clock) begin
    if (reset) begin
      mtime             <= '0;
      mtimecmp          <= '1;
      mt_en             <= 1'b0;
      mt_write_response <= 1'b0;
      mt_irq            <= 1'b0;
    end else begin
      mt_write_response <= mt_write_request;
      mt_irq <= mt_en && (mtime >= mtimecmp);
      if (load)
        mtime <= load_val;
      else if (mt_en)
        mtime <= mtime + 64'd1;
      if (mt_write_request) begin
        wlog.push_back({mt_address, mt_write_data});
        case (mt_address)
          5'h00: mt_en <= mt_write_data[0];
          5'h0C: mtimecmp[31:0] <= mt_write_data;
          5'h10: mtimecmp[63:32] <= mt_write_data;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(string tag);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk(tag, cmd_ready, 1);
  endtask

  task automatic send(logic op, logic [1:0] ch,
                      logic [63:0] dl);
    wait_ready("send_rdy");
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_channel  = ch;
    cmd_deadline = dl;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pend(string tag, logic [3:0] m);
    int n = 0;
    while ((expired_pending & m) == 0 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 64'((expired_pending & m) != 0), 1);
  endtask

  // last three writes must be HMAX, LO, HI for dl
  task automatic chk_prog(string tag, logic [63:0] dl);
    int n = wlog.size();
    if (n < 3) begin
      chk({tag, "_cnt"}, 64'(n), 3);
    end else begin
      chk({tag, "_hmax"}, wlog[n-3],
          {5'h10, 32'hFFFF_FFFF});
      chk({tag, "_lo"}, wlog[n-2], {5'h0C, dl[31:0]});
      chk({tag, "_hi"}, wlog[n-1], {5'h10, dl[63:32]});
    end
    wlog.delete();
  endtask

  task automatic set_mtime(logic [63:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic clear_all();
    expired_clear = 4'hF;
    tick();
    expired_clear = 4'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    repeat (3) tick();
    chk("rst_req", mt_write_request, 0);
    chk("rst_addr", mt_address, 0);
    chk("rst_data", mt_write_data, 0);
    chk("rst_pend", expired_pending, 0);
    chk("rst_irq", timer_irq, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_strobe", mt_write_strobe, 4'hF);
    reset = 1'b0;
    tick();
    chk("cr_req", mt_write_request, 1);
    chk("cr_wr", {mt_address, mt_write_data},
        {5'h00, 32'h1});
    repeat (9) tick();
    chk("boot_rdy10", cmd_ready, 0);
    tick();
    chk("boot_rdy11", cmd_ready, 1);
    chk("boot_nwr", wlog.size(), 4);
    chk("boot_cr", wlog[0], {5'h00, 32'h1});
    chk_prog("boot", ONES);
    chk("boot_irq", timer_irq, 0);

    // arm ch2=200 with exact timing, then ch0=100
    send(1'b0, 2'd2, 64'd200);
    tick();
    chk("t2_req", mt_write_request, 1);
    chk("t2_addr", mt_address, 5'h10);
    tick();
    chk("t3_req", mt_write_request, 0);
    tick();
    chk("t4_req", {mt_write_request, mt_address},
        {1'b1, 5'h0C});
    repeat (2) tick();
    chk("t6_req", {mt_write_request, mt_address},
        {1'b1, 5'h10});
    repeat (2) tick();
    chk("t8_rdy", cmd_ready, 0);
    tick();
    chk("t9_rdy", cmd_ready, 1);
    chk_prog("arm200", 64'd200);
    send(1'b0, 2'd0, 64'd100);
    wait_ready("arm100_rdy");
    chk_prog("arm100", 64'd100);
    wait_pend("exp100_wait", 4'b0001);
    chk("exp100_pend", expired_pending, 4'b0001);
    chk("exp100_time", 64'(mtime >= 64'd100), 1);
    chk("exp100_irq0", timer_irq, 0);
    tick();
    chk("exp100_irq1", timer_irq, 1);
    wait_ready("re200_rdy");
    chk_prog("re200", 64'd200);
    wait_pend("exp200_wait", 4'b0100);
    chk("exp200_pend", expired_pending, 4'b0101);
    wait_ready("empty_rdy");
    chk_prog("empty", ONES);
    expired_clear = 4'hF;
    tick();
    expired_clear = 4'h0;
    chk("clr_pend", expired_pending, 0);
    tick();
    chk("clr_irq", timer_irq, 0);

    // equal deadlines on ch1 and ch3
    set_mtime(64'd0);
    send(1'b0, 2'd1, 64'd50);
    send(1'b0, 2'd3, 64'd50);
    wait_ready("eq_rdy");
    chk_prog("eq", 64'd50);
    wait_pend("eq_wait", 4'b1010);
    chk("eq_pend", expired_pending, 4'b1010);
    wait_ready("eq_after_rdy");
    chk_prog("eq_after", ONES);
    clear_all();

    // arm then cancel before expiry
    set_mtime(64'd0);
    send(1'b0, 2'd0, 64'd100);
    wait_ready("can_arm_rdy");
    chk_prog("can_arm", 64'd100);
    send(1'b1, 2'd0, 64'd0);
    wait_ready("can_rdy");
    chk_prog("can", ONES);
    n = 0;
    while (mtime < 64'd150 && n < 400) begin
      tick();
      n++;
    end
    chk("can_time", 64'(mtime >= 64'd150), 1);
    chk("can_pend", expired_pending, 0);

    // past deadline
    send(1'b0, 2'd1, 64'd0);
    repeat (8) tick();
    chk("past_rdy", cmd_ready, 0);
    tick();
    chk("past_pend", expired_pending, 4'b0010);
    wait_ready("past_after_rdy");
    chk_prog("past_after", ONES);
    clear_all();

    // clear colliding with expiry
    set_mtime(64'd0);
    send(1'b0, 2'd1, 64'd40);
    wait_ready("col_rdy");
    chk_prog("col", 64'd40);
    n = 0;
    while (!mt_irq && n < 200) begin
      tick();
      n++;
    end
    chk("col_mtirq", mt_irq, 1);
    chk("col_busy", cmd_ready, 0);
    expired_clear = 4'b0010;
    tick();
    chk("col_set_wins", expired_pending, 4'b0010);
    tick();
    chk("col_cleared", expired_pending, 0);
    chk("col_irq_hold", timer_irq, 1);
    expired_clear = 4'b0000;
    tick();
    chk("col_irq_fall", timer_irq, 0);

    // reset in the middle of a programming sequence
    send(1'b0, 2'd2, 64'd500);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("mid_rst_pend", expired_pending, 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("mid_rdy10", cmd_ready, 0);
    tick();
    chk("mid_rdy11", cmd_ready, 1);
    chk_prog("mid", ONES);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/rvx_timer_scheduler.md
# rvx_timer_scheduler

Multiplexes up to NUM_CHANNELS independent 64-bit software deadlines onto the single machine timer (rvx_mtimer). The scheduler sits between a host command port and the timer's IO write interface, where it acts as the only write master. It keeps a deadline table and always programs mtimecmp with the earliest armed deadline, using the glitch-free high/low/high sequence. When the timer interrupt fires, it retires every expired channel into a sticky pending mask.

## Interface
- NUM_CHANNELS, 4: number of deadline channels, 1..16.
- CH_W, $clog2(NUM_CHANNELS) (min 1): channel index width.

- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_op  in  1  0 = arm, 1 = cancel
- cmd_channel  in  CH_W  target channel
- cmd_deadline  in  64  absolute mtime deadline (arm only)
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- expired_pending  out  NUM_CHANNELS  sticky per-channel expiry flags
- expired_clear  in  NUM_CHANNELS  write-1-to-clear for expired_pending
- timer_irq  out  1  registered OR of expired_pending
- mt_address  out  5  timer byte address
- mt_write_data  out  32  timer write data
- mt_write_strobe  out  4  constant 4'hF
- mt_write_request  out  1  one-cycle write pulse
- mt_write_response  in  1  timer write acknowledge
- mt_irq  in  1  timer interrupt (mtime >= mtimecmp)

## Operation
- Table: per channel valid bit + 64-bit deadline; all invalid after reset.
- Timer map: CR 0x00 (bit0 enable), MTIMECMPL 0x0C, MTIMECMPH 0x10.
- FSM states: INIT, SCAN, WR_HMAX, WR_LO, WR_HI, SETTLE, ARMED.
- INIT (entered from reset): write CR = 1, then go to SCAN.
- SCAN, one cycle:
  - Pick the minimum deadline among valid channels; equal deadlines go to the lowest index.
  - Latch target_deadline and target_valid.
  - If no channel is valid: target_valid = 0 and target_deadline = 64'hFFFF_FFFF_FFFF_FFFF.
- WR_HMAX writes MTIMECMPH = 32'hFFFF_FFFF.
- WR_LO writes MTIMECMPL = target[31:0].
- WR_HI writes MTIMECMPH = target[63:32].
- SETTLE: one idle cycle so the timer's registered irq reflects the new compare value. Then go to ARMED.
- cmd_ready = (state == ARMED) & ~(mt_irq & target_valid).
- Arm command: set valid, overwrite deadline (re-arming an armed channel replaces it), go to SCAN.
- Cancel command: clear valid, go to SCAN. Cancelling an invalid channel is legal and still rescans.
- Expiry, in ARMED when mt_irq & target_valid:
  - Every valid channel whose deadline <= target_deadline sets its pending bit and clears its valid bit.
  - Then go to SCAN.
- In ARMED with target_valid = 0, mt_irq is ignored.
- Pending update: the set from expiry wins over expired_clear on the same bit in the same cycle. Clear is honoured in every state.
- A deadline already in the past is still programmed; it expires once ARMED is reached.

## Timing
- Reset values:
  - all outputs 0, including cmd_ready, mt_write_request, mt_address, mt_write_data, expired_pending, timer_irq;
  - mt_write_strobe = 4'hF;
  - table all invalid; state INIT.
- Write handshake:
  - mt_write_request is high only in the first cycle of each write state.
  - Address and data are held stable until mt_write_response.
  - The state advances on the response cycle.
  - With rvx_mtimer each write takes 2 cycles.
- Command accepted in ARMED at cycle t:
  - SCAN at t+1;
  - WR_HMAX request at t+2, WR_LO request at t+4, WR_HI request at t+6;
  - SETTLE at t+8, ARMED (cmd_ready high) at t+9.
- Expiry detected at cycle t: pending bits visible at t+1, timer_irq at t+2.
- After reset release: CR write request at cycle 1, then the sequence above; first ARMED at cycle 11.
- Reset mid-sequence: the in-flight write is abandoned, the table is cleared, INIT restarts.

## Test plan
- Reset, no commands:
  - CR written with 1, then CMPH=FFFFFFFF, CMPL=FFFFFFFF, CMPH=FFFFFFFF;
  - cmd_ready rises at cycle 11; timer_irq stays 0.
- Arm ch2 = 200, then ch0 = 100:
  - the second sequence programs CMPL=100, CMPH=0;
  - when mtime reaches 100, expired_pending = 4'b0001;
  - rescan programs 200; later expired_pending = 4'b0101.
- Arm ch1 = 50 and ch3 = 50 (equal deadlines):
  - both pending bits set on the same expiry;
  - the next program is all-ones.
- Arm ch0 = 100, then cancel ch0 before mtime reaches 100:
  - compare reprogrammed to all-ones;
  - no pending bit at mtime = 150.
- Arm ch1 = 0 (a past deadline):
  - expired_pending[1] = 1 within 2 cycles of ARMED.
- Assert expired_clear[1] on the same cycle ch1 expires:
  - bit stays 1;
  - a clear one cycle later drops it and timer_irq falls the cycle after.
